snoop_responder: RTL and testbench

- Models the "other caches" end of the shared bus.
- The cache side (processor / mesi_fsm path) issues a bus operation (READ, WRITE, INVALIDATE, RWIM) on a valid/ready request channel.
- This block answers with a snoop result (HIT, HITM, NOHIT) after a programmable latency, driving the hit/hitM inputs that mesi_fsm consumes.
- HITM on READ/RWIM adds a modelled writeback delay; statistics counters are kept for the bench.

---
 rtl/snoop_responder_pkg.sv | 38 +++
 rtl/snoop_responder_sat_counter.sv | 16 +
 rtl/snoop_responder.sv | 126 ++++++++++++
 tb/tb_snoop_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/snoop_responder_pkg.sv
// Shared bus-snoop types and the snoop decision rule used by the responder
// and by anything on the cache side that needs the same answer.
package snoop_responder_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    BUS_READ       = 3'd1,
    BUS_WRITE      = 3'd2,
    BUS_INVALIDATE = 3'd3,
    BUS_RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2
  } snoop_result_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_WRITEBACK = 2'd2,
    S_RESPOND   = 2'd3
  } snoop_state_t;

  // Only reads can find a line elsewhere; writes, invalidates and unknown
  // opcodes never see a sharer.
  function automatic snoop_result_t get_snoop_result(logic [2:0] op, logic [1:0] addr_lsb);
    if (op != BUS_READ && op != BUS_RWIM) return SNP_NOHIT;
    case (addr_lsb)
      2'b00:   return SNP_HIT;
      2'b01:   return SNP_HITM;
      default: return SNP_NOHIT;
    endcase
  endfunction

endpackage

// File: rtl/snoop_responder_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst)                       value <= '0;
    else if (inc && value != '1)   value <= value + 1'b1;
  end

endmodule

// File: rtl/snoop_responder.sv
// "Other caches" model on the shared bus: answers each bus operation with a
// snoop result after a fixed lookup latency, plus a writeback stall on HITM.
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int SNOOP_LAT = 2,
  parameter int WB_LAT    = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_result,
  output logic             hit,
  output logic             hitM,
  output logic             wb_busy,
  output logic [CNT_W-1:0] cnt_ops,
  output logic [CNT_W-1:0] cnt_hit,
  output logic [CNT_W-1:0] cnt_hitm
);

  localparam logic [LAT_W-1:0] LOOKUP_LOAD = LAT_W'(SNOOP_LAT - 1);
  localparam logic [LAT_W-1:0] WB_LOAD     = LAT_W'(WB_LAT - 1);

  snoop_state_t     state;
  logic [LAT_W-1:0] wait_cnt;
  logic [2:0]       op_q;
  logic [1:0]       addr_lsb;
  snoop_result_t    result_q;
  snoop_result_t    lookup_res;
  logic             accept;
  logic             rsp_fire;

  // Only the line-offset bits decide the snoop outcome.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:2];

  assign lookup_res = get_snoop_result(op_q, addr_lsb);
  assign accept     = req_valid && req_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign rsp_result = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      op_q      <= '0;
      addr_lsb  <= '0;
      result_q  <= SNP_NOHIT;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      hit       <= 1'b0;
      hitM      <= 1'b0;
      wb_busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_lsb  <= req_addr[1:0];
            wait_cnt  <= LOOKUP_LOAD;
            req_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (wait_cnt == '0) begin
            result_q <= lookup_res;
            // HITM only arises for READ/RWIM, so it always implies a flush.
            if (lookup_res == SNP_HITM) begin
              wait_cnt <= WB_LOAD;
              wb_busy  <= 1'b1;
              state    <= S_WRITEBACK;
            end else begin
              rsp_valid <= 1'b1;
              hit       <= (lookup_res == SNP_HIT);
              hitM      <= 1'b0;
              state     <= S_RESPOND;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (wait_cnt == '0) begin
            wb_busy   <= 1'b0;
            rsp_valid <= 1'b1;
            hit       <= 1'b0;
            hitM      <= 1'b1;
            state     <= S_RESPOND;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            hit       <= 1'b0;
            hitM      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_ops (
    .clk(clk), .rst(rst), .inc(accept), .value(cnt_ops)
  );

  sat_counter #(.W(CNT_W)) u_cnt_hit (
    .clk(clk), .rst(rst), .inc(rsp_fire && result_q == SNP_HIT), .value(cnt_hit)
  );

  sat_counter #(.W(CNT_W)) u_cnt_hitm (
    .clk(clk), .rst(rst), .inc(rsp_fire && result_q == SNP_HITM), .value(cnt_hitm)
  );

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with SNOOP_LAT=2, WB_LAT=4 and 4-bit
// counters so saturation is reachable quickly.
module tb_snoop_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_result;
  logic        hit, hitM, wb_busy;
  logic [3:0]  cnt_ops, cnt_hit, cnt_hitm;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  snoop_responder #(.SNOOP_LAT(2), .WB_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .hit(hit), .hitM(hitM), .wb_busy(wb_busy),
    .cnt_ops(cnt_ops), .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one accept edge.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
  endtask

  // Cycles from accept edge until rsp_valid, counting wb_busy cycles; bounded.
  task automatic wait_rsp(output int cyc, output int wb);
    cyc = 0;
    wb  = 0;
    while (!rsp_valid && cyc < 64) begin
      if (wb_busy) wb++;
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc, wb;
    logic seen;

    // 1. reset state
    do_reset();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 2);
    chk("rst_hit", {hit, hitM}, 0);
    chk("rst_wb_busy", wb_busy, 0);
    chk("rst_counters", {cnt_ops, cnt_hit, cnt_hitm}, 0);

    // 2. READ HIT
    do_req(3'd1, 32'h984DE130);
    chk("t2_ready_low", req_ready, 0);
    chk("t2_ops", cnt_ops, 1);
    wait_rsp(cyc, wb);
    chk("t2_latency", cyc, 2);
    chk("t2_wb", wb, 0);
    chk("t2_result", rsp_result, 0);
    chk("t2_hit_hitm", {hit, hitM}, 2'b10);
    tick();
    chk("t2_cnt_hit", cnt_hit, 1);
    chk("t2_rsp_drop", rsp_valid, 0);
    chk("t2_ready_back", req_ready, 1);

    // 3. READ HITM with writeback
    do_req(3'd1, 32'h777DE131);
    wait_rsp(cyc, wb);
    chk("t3_latency", cyc, 6);
    chk("t3_wb_cycles", wb, 4);
    chk("t3_result", rsp_result, 1);
    chk("t3_hit_hitm", {hit, hitM}, 2'b01);
    chk("t3_wb_off", wb_busy, 0);
    tick();
    chk("t3_counts", {cnt_ops, cnt_hit, cnt_hitm}, {4'd2, 4'd1, 4'd1});

    // 4. WRITE, RWIM and illegal op all NOHIT
    do_reset();
    do_req(3'd2, 32'h777DE131);
    wait_rsp(cyc, wb);
    chk("t4w_latency", cyc, 2);
    chk("t4w_wb", wb, 0);
    chk("t4w_result", rsp_result, 2);
    chk("t4w_hit_hitm", {hit, hitM}, 0);
    tick();
    do_req(3'd4, 32'h116DE12F);
    wait_rsp(cyc, wb);
    chk("t4r_latency", cyc, 2);
    chk("t4r_result", rsp_result, 2);
    tick();
    chk("t4_ops", cnt_ops, 2);
    do_req(3'd0, 32'h00000000);
    wait_rsp(cyc, wb);
    chk("t4i_latency", cyc, 2);
    chk("t4i_result", rsp_result, 2);
    tick();
    chk("t4_counts", {cnt_ops, cnt_hit, cnt_hitm}, {4'd3, 4'd0, 4'd0});

    // 5. response back-pressure; pending request must wait
    rsp_ready = 1'b0;
    do_req(3'd1, 32'h00000004);
    wait_rsp(cyc, wb);
    chk("t5_latency", cyc, 2);
    req_valid = 1'b1;
    req_op    = 3'd2;
    req_addr  = 32'h00000008;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_result", rsp_result, 0);
      chk("t5_hold_ready", req_ready, 0);
    end
    chk("t5_hold_ops", cnt_ops, 4);
    rsp_ready = 1'b1;
    tick();
    chk("t5_hs_valid", rsp_valid, 0);
    chk("t5_hs_ready", req_ready, 1);
    chk("t5_hs_ops", cnt_ops, 4);
    chk("t5_hs_hit", cnt_hit, 1);
    tick();
    req_valid = 1'b0;
    chk("t5_accept_ready", req_ready, 0);
    chk("t5_accept_ops", cnt_ops, 5);
    wait_rsp(cyc, wb);
    chk("t5_second_result", rsp_result, 2);
    tick();

    // 6. reset during WRITEBACK
    do_req(3'd4, 32'h00000001);
    tick();
    tick();
    chk("t6_in_wb", wb_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_wb_clear", wb_busy, 0);
    chk("t6_ready", req_ready, 1);
    chk("t6_counters", {cnt_ops, cnt_hit, cnt_hitm}, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    chk("t6_no_rsp", seen, 0);

    // reset wins over a simultaneous request
    rst = 1'b1;
    req_valid = 1'b1;
    req_op = 3'd1;
    req_addr = 32'h0;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    chk("t6_rst_req_ops", cnt_ops, 0);
    chk("t6_rst_req_ready", req_ready, 1);

    // counter saturation at 4 bits
    for (int i = 0; i < 17; i++) begin
      do_req(3'd1, 32'h00000010);
      wait_rsp(cyc, wb);
      tick();
    end
    chk("sat_ops", cnt_ops, 15);
    chk("sat_hit", cnt_hit, 15);
    chk("sat_hitm", cnt_hitm, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
